// File: rtl/stage_mem_if.sv
// Data-bus bundle between the MEM stage (master) and the data memory/bus (slave).
interface stage_mem_if;
  logic        dbus_req;
  logic        dbus_we;
  logic [31:0] dbus_addr;
  logic [31:0] dbus_wdata;
  logic [3:0]  dbus_be;
  logic        dbus_ack;
  logic [31:0] dbus_rdata;

  modport master (
    output dbus_req, dbus_we, dbus_addr, dbus_wdata, dbus_be,
    input  dbus_ack, dbus_rdata
  );

  modport slave (
    input  dbus_req, dbus_we, dbus_addr, dbus_wdata, dbus_be,
    output dbus_ack, dbus_rdata
  );
endinterface

// File: rtl/stage_mem.sv
// MEM pipeline stage: issues loads/stores on a req/ack data bus and registers writeback.
// Optional MEM_MISALIGN_TRAP_EN: misaligned H/W accesses are flagged instead of issued.
module stage_mem (
  input  logic        clk,
  input  logic        rst,
  input  logic        me_valid,
  input  logic [31:0] me_alu_o,
  input  logic [31:0] me_regs_data2,
  input  logic [2:0]  me_func3_code,
  input  logic        me_mem_read,
  input  logic        me_mem_write,
  input  logic        me_regs_write,
  input  logic [4:0]  me_rd,
  stage_mem_if.master dbus,
  output logic        mem_stall,
  output logic [31:0] w_regs_data,
  output logic [4:0]  w_rd,
  output logic        w_regs_write,
  output logic        w_valid,
  output logic        w_misalign
);

  typedef enum logic {IDLE, BUSY} state_t;
  state_t state, state_nxt;

  logic        mem_op;
  logic        accept;
  logic        misalign;
  logic        is_b, is_h;
  logic [1:0]  off;
  logic [3:0]  be_in;
  logic [31:0] wdata_in;

  logic [31:0] cap_addr;
  logic [31:0] cap_wdata;
  logic [3:0]  cap_be;
  logic [2:0]  cap_f3;
  logic [1:0]  cap_lane;
  logic [4:0]  cap_rd;
  logic        cap_store;
  logic        cap_rw;

  logic [31:0] shifted;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_data;

  assign mem_op = me_valid & (me_mem_read | me_mem_write);

  // func3[1:0] alone decides size: 00 byte, 01 half, anything else word.
  always_comb begin
    is_b     = (me_func3_code[1:0] == 2'b00);
    is_h     = (me_func3_code[1:0] == 2'b01);
    off      = 2'b00;
    be_in    = 4'b1111;
    wdata_in = me_regs_data2;
    if (is_b) begin
      off      = me_alu_o[1:0];
      be_in    = 4'b0001 << off;
      wdata_in = {4{me_regs_data2[7:0]}};
    end else if (is_h) begin
      off      = {me_alu_o[1], 1'b0};
      be_in    = 4'b0011 << off;
      wdata_in = {2{me_regs_data2[15:0]}};
    end
  end

`ifdef MEM_MISALIGN_TRAP_EN
  assign misalign = (is_h & me_alu_o[0]) | (~is_b & ~is_h & (|me_alu_o[1:0]));
`else
  assign misalign = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    mem_stall = 1'b0;
    accept    = 1'b0;
    if (!rst) begin
      case (state)
        IDLE: begin
          if (mem_op && !misalign) begin
            accept    = 1'b1;
            mem_stall = 1'b1;
            state_nxt = BUSY;
          end
        end
        BUSY: begin
          if (dbus.dbus_ack) state_nxt = IDLE;
          else               mem_stall = 1'b1;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cap_addr  <= '0;
      cap_wdata <= '0;
      cap_be    <= '0;
      cap_f3    <= '0;
      cap_lane  <= '0;
      cap_rd    <= '0;
      cap_store <= 1'b0;
      cap_rw    <= 1'b0;
    end else if (accept) begin
      cap_addr  <= {me_alu_o[31:2], 2'b00};
      cap_wdata <= wdata_in;
      cap_be    <= be_in;
      cap_f3    <= me_func3_code;
      cap_lane  <= off;
      cap_rd    <= me_rd;
      cap_store <= me_mem_write;
      cap_rw    <= me_regs_write;
    end
  end

  assign dbus.dbus_req   = (state == BUSY);
  assign dbus.dbus_we    = (state == BUSY) & cap_store;
  assign dbus.dbus_addr  = cap_addr;
  assign dbus.dbus_wdata = cap_wdata;
  assign dbus.dbus_be    = cap_be;

  always_comb begin
    shifted  = dbus.dbus_rdata >> {cap_lane, 3'b000};
    byte_sel = shifted[7:0];
    half_sel = cap_lane[1] ? dbus.dbus_rdata[31:16] : dbus.dbus_rdata[15:0];
    case (cap_f3)
      3'b000:  load_data = {{24{byte_sel[7]}}, byte_sel};
      3'b001:  load_data = {{16{half_sel[15]}}, half_sel};
      3'b100:  load_data = {24'h000000, byte_sel};
      3'b101:  load_data = {16'h0000, half_sel};
      default: load_data = dbus.dbus_rdata;
    endcase
  end

  // Default each cycle is a bubble; a trapped misaligned op falls into the
  // IDLE pass-through path with regs_write suppressed by mem_op.
  always_ff @(posedge clk) begin
    if (rst) begin
      w_regs_data  <= '0;
      w_rd         <= '0;
      w_regs_write <= 1'b0;
      w_valid      <= 1'b0;
    end else begin
      w_valid      <= 1'b0;
      w_regs_write <= 1'b0;
      if (state == IDLE && !accept) begin
        w_regs_data  <= me_alu_o;
        w_rd         <= me_rd;
        w_valid      <= me_valid;
        w_regs_write <= me_valid & me_regs_write & ~mem_op;
      end else if (state == BUSY && dbus.dbus_ack) begin
        w_regs_data  <= load_data;
        w_rd         <= cap_rd;
        w_valid      <= 1'b1;
        w_regs_write <= cap_rw & ~cap_store;
      end
    end
  end

`ifdef MEM_MISALIGN_TRAP_EN
  always_ff @(posedge clk) begin
    if (rst) w_misalign <= 1'b0;
    else     w_misalign <= (state == IDLE) & mem_op & misalign;
  end
`else
  assign w_misalign = 1'b0;
`endif

endmodule

// File: tb/tb_stage_mem.sv
// Self-checking bench for stage_mem: vector table driven through a bus responder,
// writeback checked against a scoreboard of expected results.
module tb_stage_mem;

  logic        clk = 1'b0;
  logic        rst;
  logic        me_valid;
  logic [31:0] me_alu_o;
  logic [31:0] me_regs_data2;
  logic [2:0]  me_func3_code;
  logic        me_mem_read;
  logic        me_mem_write;
  logic        me_regs_write;
  logic [4:0]  me_rd;
  logic        mem_stall;
  logic [31:0] w_regs_data;
  logic [4:0]  w_rd;
  logic        w_regs_write;
  logic        w_valid;
  logic        w_misalign;

  stage_mem_if dbus_if ();

  always #5 clk = ~clk;

  stage_mem dut (
    .clk           (clk),
    .rst           (rst),
    .me_valid      (me_valid),
    .me_alu_o      (me_alu_o),
    .me_regs_data2 (me_regs_data2),
    .me_func3_code (me_func3_code),
    .me_mem_read   (me_mem_read),
    .me_mem_write  (me_mem_write),
    .me_regs_write (me_regs_write),
    .me_rd         (me_rd),
    .dbus          (dbus_if),
    .mem_stall     (mem_stall),
    .w_regs_data   (w_regs_data),
    .w_rd          (w_rd),
    .w_regs_write  (w_regs_write),
    .w_valid       (w_valid),
    .w_misalign    (w_misalign)
  );

  // mode: 0 = non-memory op, 1 = bus access, 2 = trapped misaligned access
  typedef struct {
    int          mode;
    logic [2:0]  f3;
    logic        rd_op;
    logic        wr_op;
    logic [31:0] addr;
    logic [31:0] sdata;
    logic [31:0] rdata;
    int          d;
    logic [4:0]  rd;
    logic        rw_in;
    logic [31:0] exp_addr;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    logic [31:0] exp_data;
    logic        exp_rw;
    logic        chk_data;
    logic        exp_mis;
  } vec_t;

  typedef struct {
    int          idx;
    logic [31:0] data;
    logic [4:0]  rd;
    logic        rw;
    logic        chk_data;
    logic        mis;
  } wb_t;

  vec_t vq[$];
  wb_t  sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic vec_t mk(int mode, logic [2:0] f3, logic rd_op, logic wr_op,
                              logic [31:0] addr, logic [31:0] sdata, logic [31:0] rdata,
                              int d, logic [4:0] rd, logic rw_in, logic [31:0] exp_addr,
                              logic [3:0] exp_be, logic [31:0] exp_wdata,
                              logic [31:0] exp_data, logic exp_rw, logic chk_data,
                              logic exp_mis);
    vec_t v;
    v.mode = mode; v.f3 = f3; v.rd_op = rd_op; v.wr_op = wr_op;
    v.addr = addr; v.sdata = sdata; v.rdata = rdata; v.d = d;
    v.rd = rd; v.rw_in = rw_in; v.exp_addr = exp_addr; v.exp_be = exp_be;
    v.exp_wdata = exp_wdata; v.exp_data = exp_data; v.exp_rw = exp_rw;
    v.chk_data = chk_data; v.exp_mis = exp_mis;
    return v;
  endfunction

  task automatic check(input string name, input int idx, input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s vec %0d: got %h, expected %h", name, idx, got, exp);
    end
  endtask

  always @(negedge clk) begin
    wb_t e;
    if (w_valid === 1'b1) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL wb_unexpected: got w_valid=1 rd=%0d, expected no writeback", w_rd);
      end else begin
        e = sb.pop_front();
        check("wb_rd", e.idx, 32'(w_rd), 32'(e.rd));
        check("wb_regs_write", e.idx, 32'(w_regs_write), 32'(e.rw));
        check("wb_misalign", e.idx, 32'(w_misalign), 32'(e.mis));
        if (e.chk_data) check("wb_data", e.idx, w_regs_data, e.data);
      end
    end
  end

  task automatic idle_inputs();
    me_valid = 1'b0; me_mem_read = 1'b0; me_mem_write = 1'b0; me_regs_write = 1'b0;
  endtask

  task automatic run_vec(input int i, input vec_t v);
    wb_t e;
    int  stalls;
    @(posedge clk); #1;
    me_valid      = 1'b1;
    me_alu_o      = v.addr;
    me_regs_data2 = v.sdata;
    me_func3_code = v.f3;
    me_mem_read   = v.rd_op;
    me_mem_write  = v.wr_op;
    me_regs_write = v.rw_in;
    me_rd         = v.rd;
    e.idx = i; e.data = v.exp_data; e.rd = v.rd; e.rw = v.exp_rw;
    e.chk_data = v.chk_data; e.mis = v.exp_mis;
    sb.push_back(e);
    @(negedge clk);
    check("stall_entry", i, 32'(mem_stall), (v.mode == 1) ? 32'd1 : 32'd0);
    check("req_entry", i, 32'(dbus_if.dbus_req), 32'd0);
    stalls = (mem_stall === 1'b1) ? 1 : 0;
    if (v.mode == 1) begin
      for (int k = 1; k <= v.d + 1; k++) begin
        @(posedge clk); #1;
        dbus_if.dbus_ack   = (k == v.d + 1);
        dbus_if.dbus_rdata = (k == v.d + 1) ? v.rdata : ~v.rdata;
        @(negedge clk);
        check("req", i, 32'(dbus_if.dbus_req), 32'd1);
        check("we", i, 32'(dbus_if.dbus_we), 32'(v.wr_op));
        check("addr", i, dbus_if.dbus_addr, v.exp_addr);
        check("be", i, 32'(dbus_if.dbus_be), 32'(v.exp_be));
        if (v.wr_op) check("wdata", i, dbus_if.dbus_wdata, v.exp_wdata);
        check("bubble", i, 32'(w_valid), 32'd0);
        check("stall_busy", i, 32'(mem_stall), (k == v.d + 1) ? 32'd0 : 32'd1);
        if (mem_stall === 1'b1) stalls++;
      end
    end
    check("stall_cycles", i, 32'(stalls), (v.mode == 1) ? 32'(v.d + 1) : 32'd0);
    @(posedge clk); #1;
    dbus_if.dbus_ack = 1'b0;
    idle_inputs();
    @(negedge clk);
    check("wb_valid", i, 32'(w_valid), 32'd1);
    check("req_after", i, 32'(dbus_if.dbus_req), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    me_valid = 1'b1; me_mem_read = 1'b1; me_mem_write = 1'b0; me_regs_write = 1'b1;
    me_alu_o = 32'h0000_0104; me_regs_data2 = 32'h1234_5678;
    me_func3_code = 3'b010; me_rd = 5'd9;
    dbus_if.dbus_ack = 1'b0; dbus_if.dbus_rdata = 32'h0;

    // mode f3 rd wr addr sdata rdata d rd rw | exp_addr be wdata data rw chk mis
    vq.push_back(mk(1, 3'b010, 0, 1, 32'h100, 32'hDEADBEEF, 32'h0, 1, 5'd1, 0,
                    32'h100, 4'b1111, 32'hDEADBEEF, 32'h0, 0, 0, 0));
    vq.push_back(mk(1, 3'b000, 1, 0, 32'h103, 32'h0, 32'h80FF1234, 3, 5'd2, 1,
                    32'h100, 4'b1000, 32'h0, 32'hFFFFFF80, 1, 1, 0));
    vq.push_back(mk(1, 3'b101, 1, 0, 32'h102, 32'h0, 32'hBEEF0000, 0, 5'd3, 1,
                    32'h100, 4'b1100, 32'h0, 32'h0000BEEF, 1, 1, 0));
    vq.push_back(mk(1, 3'b000, 0, 1, 32'h101, 32'h123456A5, 32'h0, 2, 5'd4, 0,
                    32'h100, 4'b0010, 32'hA5A5A5A5, 32'h0, 0, 0, 0));
    vq.push_back(mk(1, 3'b001, 1, 0, 32'h100, 32'h0, 32'h00008001, 1, 5'd5, 1,
                    32'h100, 4'b0011, 32'h0, 32'hFFFF8001, 1, 1, 0));
    vq.push_back(mk(1, 3'b100, 1, 0, 32'h102, 32'h0, 32'h00C30000, 0, 5'd6, 1,
                    32'h100, 4'b0100, 32'h0, 32'h000000C3, 1, 1, 0));
    vq.push_back(mk(1, 3'b001, 0, 1, 32'h202, 32'h1234CAFE, 32'h0, 1, 5'd7, 0,
                    32'h200, 4'b1100, 32'hCAFECAFE, 32'h0, 0, 0, 0));
    vq.push_back(mk(1, 3'b010, 1, 0, 32'h204, 32'h0, 32'h13579BDF, 2, 5'd8, 1,
                    32'h204, 4'b1111, 32'h0, 32'h13579BDF, 1, 1, 0));
    vq.push_back(mk(1, 3'b011, 1, 0, 32'h300, 32'h0, 32'h89ABCDEF, 0, 5'd9, 1,
                    32'h300, 4'b1111, 32'h0, 32'h89ABCDEF, 1, 1, 0));
    vq.push_back(mk(1, 3'b000, 1, 0, 32'h101, 32'h0, 32'h00007F00, 1, 5'd10, 1,
                    32'h100, 4'b0010, 32'h0, 32'h0000007F, 1, 1, 0));
    vq.push_back(mk(0, 3'b000, 0, 0, 32'h55, 32'h0, 32'h0, 0, 5'd11, 1,
                    32'h0, 4'b0000, 32'h0, 32'h00000055, 1, 1, 0));
    vq.push_back(mk(0, 3'b000, 0, 0, 32'h99, 32'h0, 32'h0, 0, 5'd12, 0,
                    32'h0, 4'b0000, 32'h0, 32'h00000099, 0, 1, 0));
`ifdef MEM_MISALIGN_TRAP_EN
    vq.push_back(mk(2, 3'b010, 1, 0, 32'h102, 32'h0, 32'h11223344, 0, 5'd13, 1,
                    32'h0, 4'b0000, 32'h0, 32'h0, 0, 0, 1));
    vq.push_back(mk(2, 3'b001, 0, 1, 32'h101, 32'h0000BEEF, 32'h0, 0, 5'd14, 0,
                    32'h0, 4'b0000, 32'h0, 32'h0, 0, 0, 1));
`else
    vq.push_back(mk(1, 3'b010, 1, 0, 32'h102, 32'h0, 32'h11223344, 0, 5'd13, 1,
                    32'h100, 4'b1111, 32'h0, 32'h11223344, 1, 1, 0));
    vq.push_back(mk(1, 3'b001, 0, 1, 32'h101, 32'h0000BEEF, 32'h0, 1, 5'd14, 0,
                    32'h100, 4'b0011, 32'hBEEFBEEF, 32'h0, 0, 0, 0));
`endif

    // Reset held with a memory op presented: everything quiet, no stall.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_stall", -1, 32'(mem_stall), 32'd0);
    check("rst_req", -1, 32'(dbus_if.dbus_req), 32'd0);
    check("rst_we", -1, 32'(dbus_if.dbus_we), 32'd0);
    check("rst_be", -1, 32'(dbus_if.dbus_be), 32'd0);
    check("rst_addr", -1, dbus_if.dbus_addr, 32'd0);
    check("rst_wdata", -1, dbus_if.dbus_wdata, 32'd0);
    check("rst_wdata_out", -1, w_regs_data, 32'd0);
    check("rst_w_rd", -1, 32'(w_rd), 32'd0);
    check("rst_w_write", -1, 32'(w_regs_write), 32'd0);
    check("rst_w_valid", -1, 32'(w_valid), 32'd0);
    check("rst_w_misalign", -1, 32'(w_misalign), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle_inputs();

    for (int i = 0; i < vq.size(); i++) run_vec(i, vq[i]);

    // Reset while BUSY, ack one cycle later must be ignored.
    @(posedge clk); #1;
    me_valid = 1'b1; me_mem_read = 1'b1; me_regs_write = 1'b1;
    me_alu_o = 32'h400; me_func3_code = 3'b010; me_rd = 5'd20;
    @(posedge clk); #1;
    @(negedge clk);
    check("rb_req_busy", 100, 32'(dbus_if.dbus_req), 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    idle_inputs();
    @(negedge clk);
    check("rb_stall_rst", 100, 32'(mem_stall), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    dbus_if.dbus_ack = 1'b1;
    dbus_if.dbus_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    check("rb_req_after", 100, 32'(dbus_if.dbus_req), 32'd0);
    check("rb_stall_late_ack", 100, 32'(mem_stall), 32'd0);
    check("rb_no_wb", 100, 32'(w_valid), 32'd0);
    @(posedge clk); #1;
    dbus_if.dbus_ack = 1'b0;
    @(negedge clk);
    check("rb_idle_req", 100, 32'(dbus_if.dbus_req), 32'd0);
    check("rb_idle_wb", 100, 32'(w_valid), 32'd0);
    repeat (2) @(negedge clk);
    check("sb_drained", 100, 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
